// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, start bit, 8 data bits, odd parity, stop, ACK check.
// Define PS2_TX_TIMEOUT_EN to compile in the transfer watchdog (TIMEOUT_CYCLES).
`timescale 1ns/1ps
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] iData,
    input  logic       iSend,
    input  logic       iPS2_CLK,
    input  logic       iPS2_DATA,
    output logic       oPS2_CLK_LOW,
    output logic       oPS2_DATA_LOW,
    output logic       oBusy,
    output logic       oDone,
    output logic       oError
);

    localparam int CNT_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_START, S_SHIFT, S_ACK, S_WAITHI, S_DONE, S_ERR
    } state_e;

    state_e           state_q;
    logic [1:0]       clk_sync_q, dat_sync_q;
    logic             clk_prev_q;
    logic [7:0]       data_q;
    logic             parity_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       bit_idx_q;
    logic             clk_low_q, data_low_q, busy_q, done_q, error_q;
    logic             clk_s, dat_s, clk_fall;

`ifdef PS2_TX_TIMEOUT_EN
    localparam int WDT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [WDT_W-1:0] wdt_q;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    // Synchronizers reset high: an idle PS/2 bus floats high.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            clk_prev_q <= 1'b1;
        end else begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values.
            clk_sync_q <= {clk_sync_q[0], iPS2_CLK};
            dat_sync_q <= {dat_sync_q[0], iPS2_DATA};
            clk_prev_q <= clk_sync_q[1];
        end
    end

    assign clk_s    = clk_sync_q[1];
    assign dat_s    = dat_sync_q[1];
    assign clk_fall = clk_prev_q & ~clk_s;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q    <= S_IDLE;
            data_q     <= '0;
            parity_q   <= 1'b0;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            clk_low_q  <= 1'b0;
            data_low_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
            wdt_q      <= '0;
`endif
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                S_IDLE: if (iSend) begin
                    data_q    <= iData;
                    parity_q  <= ~^iData;
                    cnt_q     <= CNT_W'(INHIBIT_CYCLES - 1);
                    busy_q    <= 1'b1;
                    clk_low_q <= 1'b1;
                    data_low_q <= 1'b0;
                    state_q   <= S_INHIBIT;
                end
                S_INHIBIT: begin
                    if (cnt_q == '0) begin
                        data_low_q <= 1'b1;
                        state_q    <= S_START;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_START: begin
                    clk_low_q <= 1'b0;
                    bit_idx_q <= '0;
                    state_q   <= S_SHIFT;
`ifdef PS2_TX_TIMEOUT_EN
                    wdt_q     <= '0;
`endif
                end
                S_SHIFT: if (clk_fall) begin
                    if (bit_idx_q == 4'd10) begin
                        state_q <= S_ACK;
                    end else begin
                        if (bit_idx_q < 4'd8)
                            data_low_q <= ~data_q[bit_idx_q[2:0]];
                        else if (bit_idx_q == 4'd8)
                            data_low_q <= ~parity_q;
                        else
                            data_low_q <= 1'b0;
                        bit_idx_q <= bit_idx_q + 1'b1;
                    end
                end
                S_ACK:    state_q <= dat_s ? S_ERR : S_WAITHI;
                S_WAITHI: if (clk_s) state_q <= S_DONE;
                S_DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                S_ERR: begin
                    error_q    <= 1'b1;
                    busy_q     <= 1'b0;
                    clk_low_q  <= 1'b0;
                    data_low_q <= 1'b0;
                    state_q    <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
`ifdef PS2_TX_TIMEOUT_EN
            // NOTE: placed after the case so an expiry overrides the per-state next values.
            if (state_q == S_SHIFT || state_q == S_ACK || state_q == S_WAITHI) begin
                if (wdt_q == WDT_W'(TIMEOUT_CYCLES - 1)) begin
                    clk_low_q  <= 1'b0;
                    data_low_q <= 1'b0;
                    state_q    <= S_ERR;
                end else begin
                    wdt_q <= wdt_q + 1'b1;
                end
            end
`endif
        end
    end

    assign oPS2_CLK_LOW  = clk_low_q;
    assign oPS2_DATA_LOW = data_low_q;
    assign oBusy         = busy_q;
    assign oDone         = done_q;
    assign oError        = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: device model on an open-drain bus, random bytes vs. a frame model.
`timescale 1ns/1ps
module tb_ps2_host_tx;

    localparam int INHIBIT = 50;
    localparam int TIMEOUT = 1000;
    localparam int HALF    = 100;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic [7:0] iData = '0;
    logic       iSend = 1'b0;
    logic       dev_clk_low = 1'b0, dev_data_low = 1'b0;
    logic       oPS2_CLK_LOW, oPS2_DATA_LOW, oBusy, oDone, oError;
    logic       ps2_clk, ps2_data;

    assign ps2_clk  = ~(oPS2_CLK_LOW | dev_clk_low);
    assign ps2_data = ~(oPS2_DATA_LOW | dev_data_low);

    ps2_host_tx #(.INHIBIT_CYCLES(INHIBIT), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .Clock(Clock), .Reset(Reset), .iData(iData), .iSend(iSend),
        .iPS2_CLK(ps2_clk), .iPS2_DATA(ps2_data),
        .oPS2_CLK_LOW(oPS2_CLK_LOW), .oPS2_DATA_LOW(oPS2_DATA_LOW),
        .oBusy(oBusy), .oDone(oDone), .oError(oError)
    );

    always #5 Clock = ~Clock;

    int checks = 0, failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Bus activity monitor sampled on the inactive edge.
    int cyc = 0, inh_cycles = 0, start_cycles = 0, done_cycles = 0, err_cycles = 0;
    int both_cycles = 0, err_line_bad = 0, start_cyc = 0, err_cyc = 0;

    always @(negedge Clock) begin
        cyc++;
        if (oPS2_CLK_LOW && !oPS2_DATA_LOW) inh_cycles++;
        if (oPS2_CLK_LOW && oPS2_DATA_LOW) begin start_cycles++; start_cyc = cyc; end
        if (oDone) done_cycles++;
        if (oError) begin
            err_cycles++;
            err_cyc = cyc;
            if (oPS2_CLK_LOW || oPS2_DATA_LOW) err_line_bad++;
        end
        if (oDone && oError) both_cycles++;
    end

    task automatic clear_mon();
        inh_cycles = 0; start_cycles = 0; done_cycles = 0; err_cycles = 0; err_line_bad = 0;
    endtask

    // Reference frame as the device should see it: {stop, odd parity, data LSB-first}.
    function automatic logic [9:0] expect_frame(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, b};
    endfunction

    task automatic send(input logic [7:0] b);
        iData = b;
        iSend = 1'b1;
        @(negedge Clock);
        iSend = 1'b0;
        iData = 8'($urandom);
        check("busy_after_accept", 32'(oBusy), 32'(1));
    endtask

    // Device: waits for request-to-send, then clocks n_edges pulses, sampling data before each rise.
    task automatic dev_xfer(input int n_edges, input bit ack_low, output logic [9:0] frame);
        int t;
        frame = '0;
        t = 0;
        while (!oPS2_CLK_LOW && t < 200) begin @(negedge Clock); t++; end
        check("rts_clk_low", 32'(oPS2_CLK_LOW), 32'(1));
        t = 0;
        while (oPS2_CLK_LOW && t < INHIBIT + 200) begin @(negedge Clock); t++; end
        check("rts_clk_release", 32'(oPS2_CLK_LOW), 32'(0));
        check("start_bit", 32'(ps2_data), 32'(0));
        for (int k = 0; k < n_edges; k++) begin
            if (k == 10 && ack_low) dev_data_low = 1'b1;
            repeat (5) @(negedge Clock);
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge Clock);
            if (k < 10) frame[k] = ps2_data;
            dev_clk_low = 1'b0;
            repeat (HALF) @(negedge Clock);
        end
        dev_data_low = 1'b0;
    endtask

    task automatic run_xfer(input logic [7:0] b, input bit ack_low);
        logic [9:0] frame;
        clear_mon();
        send(b);
        dev_xfer(11, ack_low, frame);
        check("frame", 32'(frame), 32'(expect_frame(b)));
        check("inhibit_cycles", 32'(inh_cycles), 32'(INHIBIT));
        check("start_cycles", 32'(start_cycles), 32'(1));
        check("done_pulses", 32'(done_cycles), ack_low ? 32'(1) : 32'(0));
        check("error_pulses", 32'(err_cycles), ack_low ? 32'(0) : 32'(1));
        check("error_lines_released", 32'(err_line_bad), 32'(0));
        check("busy_end", 32'(oBusy), 32'(0));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [9:0] frame;
        int lat;
        repeat (3) @(negedge Clock);
        check("reset_outputs", 32'({oPS2_CLK_LOW, oPS2_DATA_LOW, oBusy, oDone, oError}), 32'(0));

        // First send on the first edge after reset release.
        Reset = 1'b1;
        run_xfer(8'hED, 1'b1);
        run_xfer(8'h00, 1'b1);
        run_xfer(8'hFF, 1'b1);
        run_xfer(8'h01, 1'b1);
        for (int i = 0; i < 6; i++) run_xfer(8'($urandom), 1'b1);

        // Device leaves data high at the ACK edge.
        run_xfer(8'($urandom), 1'b0);

        // Second send mid-SHIFT is ignored.
        clear_mon();
        send(8'hA3);
        fork
            dev_xfer(11, 1'b1, frame);
            begin
                repeat (INHIBIT + 800) @(negedge Clock);
                iData = 8'h55;
                iSend = 1'b1;
                @(negedge Clock);
                iSend = 1'b0;
            end
        join
        check("ignored_send_frame", 32'(frame), 32'(expect_frame(8'hA3)));
        repeat (300) @(negedge Clock);
        check("ignored_send_no_inhibit", 32'(inh_cycles), 32'(INHIBIT));
        check("ignored_send_done", 32'(done_cycles), 32'(1));
        check("ignored_send_busy", 32'(oBusy), 32'(0));

        // Asynchronous reset while bit 4 (a 0) is on the bus.
        clear_mon();
        send(8'hED);
        dev_xfer(5, 1'b1, frame);
        check("bit4_driven_low", 32'(oPS2_DATA_LOW), 32'(1));
        @(negedge Clock);
        #2 Reset = 1'b0;
        #1 check("async_reset_outputs", 32'({oPS2_CLK_LOW, oPS2_DATA_LOW, oBusy}), 32'(0));
        @(negedge Clock);
        Reset = 1'b1;
        run_xfer(8'($urandom), 1'b1);

        // Device clock stops after bit 2 (a 0 on the bus).
        clear_mon();
        send(8'hFB);
        dev_xfer(3, 1'b1, frame);
`ifdef PS2_TX_TIMEOUT_EN
        for (int t = 0; t < TIMEOUT + 500 && err_cycles == 0; t++) @(negedge Clock);
        repeat (5) @(negedge Clock);
        check("timeout_error_pulses", 32'(err_cycles), 32'(1));
        lat = err_cyc - start_cyc;
        check("timeout_latency_window", 32'(lat >= TIMEOUT && lat <= TIMEOUT + 4), 32'(1));
        check("timeout_lines_released", 32'(err_line_bad), 32'(0));
        check("timeout_busy", 32'(oBusy), 32'(0));
`else
        lat = 0;
        repeat (3 * TIMEOUT) @(negedge Clock);
        check("stall_busy", 32'(oBusy), 32'(1));
        check("stall_no_error", 32'(err_cycles + lat), 32'(0));
        Reset = 1'b0;
        @(negedge Clock);
        Reset = 1'b1;
`endif
        run_xfer(8'($urandom), 1'b1);

        check("done_and_error_exclusive", 32'(both_cycles), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
